mvu_job_dispatcher: RTL and testbench

//  Upstream of the MVU array. Queues job descriptors (MVU select mask + countdown) from the host/controller,

---
 rtl/mvu_pkg.sv | 18 +
 rtl/mvu_job_fifo.sv | 57 +++++
 rtl/mvu_job_dispatcher.sv | 163 ++++++++++++++++
 tb/tb_mvu_job_dispatcher.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared MVU types: job descriptor, queue depth and per-MVU dispatch state.
package mvu_pkg;

    localparam int NMVU           = 8;
    localparam int BCNTDWN        = 29;
    localparam int MVU_JOBQ_DEPTH = 4;

    typedef struct packed {
        logic [NMVU-1:0]    mvusel;
        logic [BCNTDWN-1:0] countdown;
    } mvu_job_t;

    typedef enum logic {
        MVU_IDLE = 1'b0,
        MVU_BUSY = 1'b1
    } mvu_state_t;

endpackage

// File: rtl/mvu_job_fifo.sv
// Synchronous job queue of mvu_job_t; head is read straight from the storage flops.
module mvu_job_fifo
    import mvu_pkg::*;
#(
    parameter int DEPTH = MVU_JOBQ_DEPTH,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  mvu_job_t      push_data,
    input  logic          pop,
    output mvu_job_t      head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    mvu_job_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// MVU job dispatcher: queues job descriptors and launches them in order onto idle MVUs,
// tracking per-MVU busy and sticky completion interrupts.
// Optional feature macro: MVU_DISPATCH_TIMEOUT_EN adds a per-MVU watchdog and the
// timeout_err output.
//
// Per-MVU state:
//   state    | meaning
//   MVU_IDLE | no outstanding job; eligible for dispatch
//   MVU_BUSY | job dispatched; waiting for done (or watchdog expiry)
module mvu_job_dispatcher
    import mvu_pkg::*;
#(
    parameter int NMVU       = mvu_pkg::NMVU,
    parameter int BCNTDWN    = mvu_pkg::BCNTDWN,
    parameter int FIFO_DEPTH = MVU_JOBQ_DEPTH,
    parameter int TIMEOUT_W  = 20,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [NMVU-1:0]                job_mvusel,
    input  logic [BCNTDWN-1:0]             job_countdown,
    output logic [NMVU-1:0]                start,
    output logic [NMVU-1:0][BCNTDWN-1:0]   countdown,
    input  logic [NMVU-1:0]                done,
    output logic [NMVU-1:0]                busy,
    output logic [NMVU-1:0]                irq,
    input  logic [NMVU-1:0]                irq_ack,
    output logic [LVL_W-1:0]               fifo_level
`ifdef MVU_DISPATCH_TIMEOUT_EN
    ,
    output logic [NMVU-1:0]                timeout_err
`endif
);

    // The descriptor struct is sized from the package, so the top must agree with it.
    if (NMVU != mvu_pkg::NMVU || BCNTDWN != mvu_pkg::BCNTDWN || TIMEOUT_W < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("mvu_job_dispatcher: illegal parameter combination");
    end

    mvu_job_t        push_job;
    mvu_job_t        head_job;
    logic            q_full;
    logic            q_empty;
    logic            dispatch;
    logic [NMVU-1:0] sel;

    assign push_job  = '{mvusel: job_mvusel, countdown: job_countdown};
    assign job_ready = ~q_full;

    // Registered busy is the only view used: a done in this cycle does not free the MVU yet.
    assign dispatch = ~q_empty && ((head_job.mvusel & busy) == '0);
    assign sel      = head_job.mvusel & {NMVU{dispatch}};

    mvu_job_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_jobq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (job_valid & job_ready),
        .push_data (push_job),
        .pop       (dispatch),
        .head      (head_job),
        .full      (q_full),
        .empty     (q_empty),
        .level     (fifo_level)
    );

    for (genvar i = 0; i < NMVU; i++) begin : g_mvu
        mvu_state_t         state_q, state_d;
        logic               irq_q, irq_d;
        logic               start_q;
        logic [BCNTDWN-1:0] cd_q, cd_d;
        logic               tmo_hit;

`ifdef MVU_DISPATCH_TIMEOUT_EN
        localparam logic [TIMEOUT_W-1:0] TMO_LAST = '1;
        logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
        logic                 terr_q, terr_d;

        // Fires on the edge where the counter reaches its last value without a done.
        assign tmo_hit        = (state_q == MVU_BUSY) && !done[i] &&
                                (tmo_cnt_q == TMO_LAST - TIMEOUT_W'(1));
        assign timeout_err[i] = terr_q;
`else
        assign tmo_hit = 1'b0;
`endif

        assign busy[i]      = (state_q == MVU_BUSY);
        assign irq[i]       = irq_q;
        assign start[i]     = start_q;
        assign countdown[i] = cd_q;

        // Next-state: dispatch/complete transitions, sticky irq with set priority over ack.
        always_comb begin
            state_d = state_q;
            irq_d   = irq_q;
            cd_d    = cd_q;
            case (state_q)
                MVU_IDLE: begin
                    if (sel[i]) begin
                        state_d = MVU_BUSY;
                        cd_d    = head_job.countdown;
                    end
                end
                MVU_BUSY: begin
                    if (done[i] || tmo_hit) begin
                        state_d = MVU_IDLE;
                    end
                end
                default: state_d = MVU_IDLE;
            endcase
            if (irq_ack[i]) begin
                irq_d = 1'b0;
            end
            if (((state_q == MVU_BUSY) && done[i]) || tmo_hit) begin
                irq_d = 1'b1;
            end
`ifdef MVU_DISPATCH_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q;
            terr_d    = terr_q;
            if (sel[i]) begin
                tmo_cnt_d = '0;
            end else if (state_q == MVU_BUSY) begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
            end
            if (irq_ack[i]) begin
                terr_d = 1'b0;
            end
            if (tmo_hit) begin
                terr_d = 1'b1;
            end
`endif
        end

        // Per-MVU state, start pulse, held countdown config and interrupt registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= MVU_IDLE;
                irq_q     <= 1'b0;
                start_q   <= 1'b0;
                cd_q      <= '0;
`ifdef MVU_DISPATCH_TIMEOUT_EN
                tmo_cnt_q <= '0;
                terr_q    <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                irq_q     <= irq_d;
                start_q   <= sel[i];
                cd_q      <= cd_d;
`ifdef MVU_DISPATCH_TIMEOUT_EN
                tmo_cnt_q <= tmo_cnt_d;
                terr_q    <= terr_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Self-checking bench for mvu_job_dispatcher; start pulses are checked against a job scoreboard.
module tb_mvu_job_dispatcher;
    import mvu_pkg::*;

    localparam int NM = 8;
    localparam int BC = 29;
    localparam int LW = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   job_valid = 1'b0;
    logic                   job_ready;
    logic [NM-1:0]          job_mvusel = '0;
    logic [BC-1:0]          job_countdown = '0;
    logic [NM-1:0]          start;
    logic [NM-1:0][BC-1:0]  countdown;
    logic [NM-1:0]          done = '0;
    logic [NM-1:0]          busy;
    logic [NM-1:0]          irq;
    logic [NM-1:0]          irq_ack = '0;
    logic [LW-1:0]          fifo_level;
`ifdef MVU_DISPATCH_TIMEOUT_EN
    logic [NM-1:0]          timeout_err;
`endif

    int        checks = 0;
    int        errors = 0;
    mvu_job_t  exp_q[$];
    mvu_job_t  mon_exp;
    logic      last_acc;
    logic      mon_bad;

    always #5 clk = ~clk;

    mvu_job_dispatcher #(
        .NMVU       (NM),
        .BCNTDWN    (BC),
        .FIFO_DEPTH (4),
        .TIMEOUT_W  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_mvusel    (job_mvusel),
        .job_countdown (job_countdown),
        .start         (start),
        .countdown     (countdown),
        .done          (done),
        .busy          (busy),
        .irq           (irq),
        .irq_ack       (irq_ack),
        .fifo_level    (fifo_level)
`ifdef MVU_DISPATCH_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    // Every start pulse must match the oldest accepted non-zero job.
    always @(negedge clk) begin
        if (rst_n && start !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL start_unexpected start=%h expected no start", start);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_bad = 1'b0;
                for (int i = 0; i < NM; i++) begin
                    if (mon_exp.mvusel[i] && countdown[i] !== mon_exp.countdown) mon_bad = 1'b1;
                end
                if (start !== mon_exp.mvusel || mon_bad) begin
                    errors++;
                    $display("FAIL start_job start=%h expected %h (countdown expected %0d)",
                             start, mon_exp.mvusel, mon_exp.countdown);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    // One negedge: drive inputs for the next posedge, record accepted jobs.
    task automatic cyc(input logic v, input logic [NM-1:0] m, input logic [BC-1:0] c,
                       input logic [NM-1:0] d, input logic [NM-1:0] a);
        @(negedge clk);
        job_valid     = v;
        job_mvusel    = m;
        job_countdown = c;
        done          = d;
        irq_ack       = a;
        last_acc      = v && job_ready;
        if (last_acc && m != '0) exp_q.push_back('{mvusel: m, countdown: c});
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #10;
        checks++; if (start !== '0)      begin errors++; $display("FAIL reset_start got=%h exp=0", start); end
        checks++; if (busy !== '0)       begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
        checks++; if (irq !== '0)        begin errors++; $display("FAIL reset_irq got=%h exp=0", irq); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", job_ready); end
        checks++; if (countdown !== '0)  begin errors++; $display("FAIL reset_countdown got=%h exp=0", countdown); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        cyc(1'b1, 8'h01, 29'd100, '0, '0);
        idle();
        checks++; if (start !== '0) begin errors++; $display("FAIL single_no_bypass start=%h exp=0", start); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
        idle();
        checks++; if (start !== 8'h01 || busy !== 8'h01 || countdown[0] !== 29'd100) begin
            errors++; $display("FAIL single_dispatch start=%h busy=%h cd0=%0d exp 01 01 100", start, busy, countdown[0]);
        end
        cyc(1'b0, '0, '0, 8'h01, '0);
        checks++; if (start !== '0 || busy !== 8'h01) begin
            errors++; $display("FAIL single_pulse start=%h busy=%h exp 00 01", start, busy);
        end
        idle();
        checks++; if (irq !== 8'h01 || busy !== '0) begin
            errors++; $display("FAIL single_done irq=%h busy=%h exp 01 00", irq, busy);
        end
        cyc(1'b0, '0, '0, '0, 8'h01);
        idle();
        checks++; if (irq !== '0) begin errors++; $display("FAIL single_ack irq=%h exp=0", irq); end
    endtask

    task automatic test_blocking();
        cyc(1'b1, 8'h03, 29'd50, '0, '0);
        cyc(1'b1, 8'h02, 29'd7, '0, '0);
        idle();
        checks++; if (start !== 8'h03 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL block_first start=%h level=%0d exp 03 1", start, fifo_level);
        end
        idle();
        idle();
        checks++; if (start !== '0 || busy !== 8'h03 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL block_wait start=%h busy=%h level=%0d exp 00 03 1", start, busy, fifo_level);
        end
        cyc(1'b0, '0, '0, 8'h02, '0);
        idle();
        checks++; if (busy !== 8'h01 || start !== '0) begin
            errors++; $display("FAIL block_freed busy=%h start=%h exp 01 00", busy, start);
        end
        idle();
        checks++; if (start !== 8'h02 || countdown[1] !== 29'd7 || countdown[0] !== 29'd50) begin
            errors++; $display("FAIL block_second start=%h cd1=%0d cd0=%0d exp 02 7 50", start, countdown[1], countdown[0]);
        end
        cyc(1'b0, '0, '0, 8'h03, '0);
        idle();
        checks++; if (irq !== 8'h03 || busy !== '0) begin
            errors++; $display("FAIL block_irq irq=%h busy=%h exp 03 00", irq, busy);
        end
        cyc(1'b0, '0, '0, '0, 8'hff);
        idle();
    endtask

    task automatic test_full();
        cyc(1'b1, 8'h01, 29'd10, '0, '0);
        cyc(1'b1, 8'h01, 29'd11, '0, '0);
        cyc(1'b1, 8'h01, 29'd12, '0, '0);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL full_pushpop level=%0d exp=1", fifo_level); end
        cyc(1'b1, 8'h01, 29'd13, '0, '0);
        cyc(1'b1, 8'h01, 29'd14, '0, '0);
        cyc(1'b1, 8'h01, 29'd15, '0, '0);
        checks++; if (job_ready !== 1'b0 || fifo_level !== 3'd4 || last_acc !== 1'b0) begin
            errors++; $display("FAIL full_refuse ready=%b level=%0d acc=%b exp 0 4 0", job_ready, fifo_level, last_acc);
        end
        cyc(1'b1, 8'h01, 29'd15, 8'h01, '0);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_hold level=%0d exp=4", fifo_level); end
        cyc(1'b1, 8'h01, 29'd15, '0, '0);
        checks++; if (busy[0] !== 1'b0 || irq[0] !== 1'b1 || job_ready !== 1'b0) begin
            errors++; $display("FAIL full_done busy0=%b irq0=%b ready=%b exp 0 1 0", busy[0], irq[0], job_ready);
        end
        cyc(1'b1, 8'h01, 29'd15, '0, '0);
        checks++; if (fifo_level !== 3'd3 || last_acc !== 1'b1) begin
            errors++; $display("FAIL full_pop level=%0d acc=%b exp 3 1", fifo_level, last_acc);
        end
        idle();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_refill level=%0d exp=4", fifo_level); end
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 8 && busy[0] !== 1'b1; k++) idle();
            checks++;
            if (busy[0] !== 1'b1) begin
                errors++; $display("FAIL drain_wait busy0=%b exp=1 within 8 cycles", busy[0]);
            end
            cyc(1'b0, '0, '0, 8'h01, '0);
            idle();
        end
        idle();
        checks++; if (fifo_level !== '0 || busy !== '0 || exp_q.size() != 0) begin
            errors++; $display("FAIL drain_end level=%0d busy=%h pending=%0d exp 0 0 0", fifo_level, busy, exp_q.size());
        end
        cyc(1'b0, '0, '0, '0, 8'hff);
        idle();
    endtask

    task automatic test_zero_mask();
        cyc(1'b1, 8'h00, 29'd9, '0, '0);
        cyc(1'b1, 8'h04, 29'd5, '0, '0);
        idle();
        checks++; if (start !== '0 || fifo_level !== 3'd1 || busy !== '0) begin
            errors++; $display("FAIL zero_discard start=%h level=%0d busy=%h exp 00 1 00", start, fifo_level, busy);
        end
        idle();
        checks++; if (start !== 8'h04 || countdown[2] !== 29'd5) begin
            errors++; $display("FAIL zero_next start=%h cd2=%0d exp 04 5", start, countdown[2]);
        end
        cyc(1'b0, '0, '0, 8'h04, '0);
        idle();
        checks++; if (irq !== 8'h04) begin errors++; $display("FAIL zero_irq irq=%h exp=04", irq); end
        cyc(1'b0, '0, '0, '0, 8'h04);
        idle();
    endtask

    task automatic test_irq_and_reset();
        cyc(1'b0, '0, '0, 8'h08, '0);
        idle();
        checks++; if (irq !== '0 || busy !== '0) begin
            errors++; $display("FAIL stray_done irq=%h busy=%h exp 00 00", irq, busy);
        end
        cyc(1'b1, 8'h01, 29'd3, '0, '0);
        idle();
        idle();
        cyc(1'b0, '0, '0, 8'h01, 8'h01);
        idle();
        checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL set_wins irq0=%b exp=1", irq[0]); end
        cyc(1'b1, 8'h01, 29'd4, '0, '0);
        idle();
        cyc(1'b1, 8'h01, 29'd6, '0, '0);
        idle();
        checks++; if (busy[0] !== 1'b1 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL pre_reset busy0=%b level=%0d exp 1 1", busy[0], fifo_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== '0 || irq !== '0 || fifo_level !== '0 || start !== '0 || countdown !== '0 || job_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset busy=%h irq=%h level=%0d start=%h ready=%b exp all clear", busy, irq, fifo_level, start, job_ready);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        checks++; if (start !== '0 || busy !== '0 || fifo_level !== '0) begin
            errors++; $display("FAIL post_reset start=%h busy=%h level=%0d exp idle", start, busy, fifo_level);
        end
    endtask

`ifdef MVU_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        logic early;
        early = 1'b0;
        cyc(1'b1, 8'h20, 29'd33, '0, '0);
        idle();
        idle();
        checks++; if (busy !== 8'h20) begin errors++; $display("FAIL tmo_dispatch busy=%h exp=20", busy); end
        for (int k = 1; k <= 14; k++) begin
            idle();
            if (busy[5] !== 1'b1 || timeout_err[5] !== 1'b0) early = 1'b1;
        end
        checks++; if (early) begin errors++; $display("FAIL tmo_early expired before 15 busy cycles"); end
        idle();
        checks++; if (busy[5] !== 1'b0 || timeout_err !== 8'h20 || irq !== 8'h20) begin
            errors++; $display("FAIL tmo_fire busy5=%b err=%h irq=%h exp 0 20 20", busy[5], timeout_err, irq);
        end
        cyc(1'b0, '0, '0, 8'h20, '0);
        idle();
        checks++; if (busy !== '0 || timeout_err !== 8'h20 || irq !== 8'h20) begin
            errors++; $display("FAIL tmo_stray busy=%h err=%h irq=%h exp 00 20 20", busy, timeout_err, irq);
        end
        cyc(1'b0, '0, '0, '0, 8'h20);
        idle();
        checks++; if (timeout_err !== '0 || irq !== '0) begin
            errors++; $display("FAIL tmo_ack err=%h irq=%h exp 00 00", timeout_err, irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_blocking();
        test_full();
        test_zero_mask();
        test_irq_and_reset();
`ifdef MVU_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover pending=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
